multicycle_cu: RTL and testbench
================================

MULTICYCLE_CU -- requirements
Module: multicycle_cu

Interface
REQ-001 Parameter DATA_WIDTH, default 8, datapath and register width.
REQ-002 Parameter NUM_REGS, default 4, register-file depth; SHALL be a power of two ≥2; REG_BITS = log2(NUM_REGS).
REQ-003 Parameter ADDR_BITS, default 5, data-memory address width.
REQ-004 Derived INSTR_WIDTH = 2 + 3*REG_BITS + DATA_WIDTH + 4, i.e. {class[1:0], rd, rs1, rs2, offset, opcode[3:0]} MSB-first.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 instr / instr_valid / instr_ready  in/in/out  INSTR_WIDTH/1/1  instruction handshake.
REQ-008 mem_addr / mem_wdata / mem_we  out  ADDR_BITS/DATA_WIDTH/1  data-memory request.
REQ-009 mem_rdata  in  DATA_WIDTH  read data, valid exactly one cycle after a read request.
REQ-010 retire / illegal  out  1/1  single-cycle completion and bad-opcode pulses.
REQ-011 flag_z / flag_c  out  1/1  zero and carry of last retired ALU op.
REQ-012 dbg_sel / dbg_data  in/out  REG_BITS/DATA_WIDTH  combinational register-file read port.

Function
REQ-013 States IDLE, DECODE, EXECUTE, MEM, WRITEBACK; any other encoding SHALL go to IDLE next cycle.
REQ-014 instr_ready SHALL be 1 only in IDLE; instruction latched when instr_valid && instr_ready; IDLE->DECODE.
REQ-015 Class 00 (NOP): DECODE->IDLE, retire pulse in DECODE, no writes.
REQ-016 Class 01 (ALU rd = rs1 op rs2): DECODE->EXECUTE->WRITEBACK->IDLE; retire in WRITEBACK.
REQ-017 Class 10 (LOAD rd = mem[rs1+offset]): DECODE->EXECUTE->MEM->WRITEBACK->IDLE; mem_we=0 in MEM; rd written from mem_rdata in WRITEBACK.
REQ-018 Class 11 (STORE mem[rs1+offset] = rs2): DECODE->EXECUTE->MEM->IDLE; mem_we=1 for exactly the MEM cycle; retire in MEM.
REQ-019 Accept-to-retire latency: NOP 1, ALU 3, STORE 3, LOAD 4 cycles; next accept earliest the cycle after retire.
REQ-020 Address = (rs1 + offset) truncated to ADDR_BITS (wraps modulo 2^ADDR_BITS).
REQ-021 Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL1, 6 SHR1, 7 PASS rs1; results modulo 2^DATA_WIDTH.
REQ-022 flag_c = carry-out (ADD), borrow (SUB), shifted-out bit (SHL1/SHR1), 0 otherwise; flag_z = result==0; both updated only on ALU retire.
REQ-023 ALU opcode 8–15: illegal pulses in EXECUTE, no register/flag write, state->IDLE, retire not asserted.
REQ-024 Opcode ignored for LOAD/STORE; illegal never asserted for them.
REQ-025 Register operands read in DECODE; rd==rs1 or rd==rs2 SHALL use pre-write values.
REQ-026 mem_addr/mem_wdata SHALL hold stable throughout MEM; mem_we=0 in all other states.

Reset
REQ-027 On rst low: state IDLE, reg[i]=i for all i (truncated to DATA_WIDTH), flags 0, mem_we/retire/illegal 0, mem_addr/mem_wdata 0.
REQ-028 Reset asserted mid-instruction SHALL abort it with no register or memory write after assertion.
REQ-029 instr_ready SHALL be 0 during reset and 1 in the first cycle after release.

Configuration
REQ-030 Macro MULTICYCLE_CU_REG0_ZERO_EN: defined -> reg[0] reads 0 always, writes to reg[0] discarded, reset value 0; undefined -> reg[0] ordinary register.

Structure
REQ-031 Shared package cu_pkg SHALL hold state enum, class codes, opcode constants, field-offset functions of REG_BITS/DATA_WIDTH.
REQ-032 ALU SHALL be sub-module cu_alu (combinational, result/carry/zero/illegal outputs); register file and FSM in multicycle_cu.

Verification
REQ-033 Reset then ALU ADD r1=r2+r3 -> retire 3 cycles after accept, dbg r1=5, flag_z=0, flag_c=0.
REQ-034 reg2=0xFF via LOAD, ADD r0=r2+r1 (r1=1) -> r0=0x00, flag_z=1, flag_c=1 (r0=0 with macro, write discarded).
REQ-035 STORE rs1=r3 offset 0x1E rs2=r2 -> one-cycle mem_we, mem_addr=0x01 (wrap), mem_wdata=2.
REQ-036 LOAD rd=r1 rs1=r0 offset 4, mem_rdata=0xA5 -> r1=0xA5 four cycles after accept.
REQ-037 ALU opcode 0xC -> illegal pulse, no retire, registers/flags unchanged, instr_ready next cycle.
REQ-038 Reset pulsed during STORE DECODE -> mem_we never asserted, registers back to reset values.

Source files
------------

// File: rtl/cu_pkg.sv
// ============================================================================
// Module      : cu_pkg
// Description : Shared types, class/opcode codes and instruction field offsets
//               for the multicycle control unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEM       = 3'd3,
        ST_WRITEBACK = 3'd4
    } state_t;

    localparam logic [1:0] CLS_NOP   = 2'b00;
    localparam logic [1:0] CLS_ALU   = 2'b01;
    localparam logic [1:0] CLS_LOAD  = 2'b10;
    localparam logic [1:0] CLS_STORE = 2'b11;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SHL1 = 4'd5;
    localparam logic [3:0] OP_SHR1 = 4'd6;
    localparam logic [3:0] OP_PASS = 4'd7;

    // Layout MSB-first: {class[1:0], rd, rs1, rs2, offset, opcode[3:0]}
    function automatic int instr_width(input int reg_bits, input int data_width);
        return 2 + 3 * reg_bits + data_width + 4;
    endfunction

    function automatic int off_lsb();
        return 4;
    endfunction

    function automatic int rs2_lsb(input int data_width);
        return data_width + 4;
    endfunction

    function automatic int rs1_lsb(input int reg_bits, input int data_width);
        return data_width + 4 + reg_bits;
    endfunction

    function automatic int rd_lsb(input int reg_bits, input int data_width);
        return data_width + 4 + 2 * reg_bits;
    endfunction

    function automatic int cls_lsb(input int reg_bits, input int data_width);
        return data_width + 4 + 3 * reg_bits;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cu_alu.sv
// ============================================================================
// Module      : cu_alu
// Description : Combinational ALU with carry/borrow, zero and illegal-opcode.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cu_alu
    import cu_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [3:0]            op,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  carry,
    output logic                  zero,
    output logic                  illegal
);

    logic [DATA_WIDTH:0] sum;
    logic [DATA_WIDTH:0] diff;

    always_comb begin
        sum     = {1'b0, a} + {1'b0, b};
        diff    = {1'b0, a} - {1'b0, b};
        result  = '0;
        carry   = 1'b0;
        illegal = 1'b0;
        case (op)
            OP_ADD:  begin result = sum[DATA_WIDTH-1:0];  carry = sum[DATA_WIDTH];  end
            // Top bit of the widened difference is set exactly when a < b
            OP_SUB:  begin result = diff[DATA_WIDTH-1:0]; carry = diff[DATA_WIDTH]; end
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_SHL1: begin result = {a[DATA_WIDTH-2:0], 1'b0}; carry = a[DATA_WIDTH-1]; end
            OP_SHR1: begin result = {1'b0, a[DATA_WIDTH-1:1]}; carry = a[0];            end
            OP_PASS: result = a;
            default: illegal = 1'b1;
        endcase
    end

    assign zero = (result == '0);

endmodule

`default_nettype wire

// File: rtl/multicycle_cu.sv
// ============================================================================
// Module      : multicycle_cu
// Description : Multicycle control unit (FSM + register file) driving cu_alu
//               and a one-cycle-latency data memory. Optional build macro
//               MULTICYCLE_CU_REG0_ZERO_EN hardwires reg[0] to zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_cu
    import cu_pkg::*;
#(
    parameter  int DATA_WIDTH  = 8,
    parameter  int NUM_REGS    = 4,
    parameter  int ADDR_BITS   = 5,
    localparam int REG_BITS    = $clog2(NUM_REGS),
    localparam int INSTR_WIDTH = instr_width(REG_BITS, DATA_WIDTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INSTR_WIDTH-1:0] instr,
    input  logic                   instr_valid,
    output logic                   instr_ready,
    output logic [ADDR_BITS-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]  mem_wdata,
    output logic                   mem_we,
    input  logic [DATA_WIDTH-1:0]  mem_rdata,
    output logic                   retire,
    output logic                   illegal,
    output logic                   flag_z,
    output logic                   flag_c,
    input  logic [REG_BITS-1:0]    dbg_sel,
    output logic [DATA_WIDTH-1:0]  dbg_data
);

    localparam int OFF_LSB = off_lsb();
    localparam int RS2_LSB = rs2_lsb(DATA_WIDTH);
    localparam int RS1_LSB = rs1_lsb(REG_BITS, DATA_WIDTH);
    localparam int RD_LSB  = rd_lsb(REG_BITS, DATA_WIDTH);
    localparam int CLS_LSB = cls_lsb(REG_BITS, DATA_WIDTH);

    state_t                 state;
    logic [INSTR_WIDTH-1:0] ir;
    logic [DATA_WIDTH-1:0]  regs [NUM_REGS];
    logic [DATA_WIDTH-1:0]  op_a;
    logic [DATA_WIDTH-1:0]  op_b;
    logic [DATA_WIDTH-1:0]  res_q;
    logic                   carry_q;
    logic                   zero_q;

    logic [1:0]            cls;
    logic [REG_BITS-1:0]   rd;
    logic [REG_BITS-1:0]   rs1;
    logic [REG_BITS-1:0]   rs2;
    logic [DATA_WIDTH-1:0] offset;
    logic [3:0]            opc;
    logic [DATA_WIDTH:0]   eff_addr;
    logic                  wr_ok;

    logic [DATA_WIDTH-1:0] alu_result;
    logic                  alu_carry;
    logic                  alu_zero;
    logic                  alu_illegal;

    assign cls      = ir[CLS_LSB +: 2];
    assign rd       = ir[RD_LSB  +: REG_BITS];
    assign rs1      = ir[RS1_LSB +: REG_BITS];
    assign rs2      = ir[RS2_LSB +: REG_BITS];
    assign offset   = ir[OFF_LSB +: DATA_WIDTH];
    assign opc      = ir[3:0];
    assign eff_addr = {1'b0, op_a} + {1'b0, offset};

`ifdef MULTICYCLE_CU_REG0_ZERO_EN
    assign wr_ok = (rd != '0);
`else
    assign wr_ok = 1'b1;
`endif

    // Gated by reset so the handshake stays closed while reset is held
    assign instr_ready = rst && (state == ST_IDLE);
    assign dbg_data    = regs[dbg_sel];

    cu_alu #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_alu (
        .a       (op_a),
        .b       (op_b),
        .op      (opc),
        .result  (alu_result),
        .carry   (alu_carry),
        .zero    (alu_zero),
        .illegal (alu_illegal)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            ir        <= '0;
            op_a      <= '0;
            op_b      <= '0;
            res_q     <= '0;
            carry_q   <= 1'b0;
            zero_q    <= 1'b0;
            flag_z    <= 1'b0;
            flag_c    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            retire    <= 1'b0;
            illegal   <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= DATA_WIDTH'(i);
            end
        end else begin
            retire  <= 1'b0;
            illegal <= 1'b0;
            mem_we  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (instr_valid && instr_ready) begin
                        ir     <= instr;
                        retire <= (instr[CLS_LSB +: 2] == CLS_NOP);
                        state  <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    // Operands captured here, so rd aliasing rs1/rs2 sees old values
                    op_a    <= regs[rs1];
                    op_b    <= regs[rs2];
                    illegal <= (cls == CLS_ALU) && alu_illegal;
                    state   <= (cls == CLS_NOP) ? ST_IDLE : ST_EXECUTE;
                end
                ST_EXECUTE: begin
                    if (cls == CLS_ALU) begin
                        if (alu_illegal) begin
                            state <= ST_IDLE;
                        end else begin
                            res_q   <= alu_result;
                            carry_q <= alu_carry;
                            zero_q  <= alu_zero;
                            retire  <= 1'b1;
                            state   <= ST_WRITEBACK;
                        end
                    end else begin
                        mem_addr  <= ADDR_BITS'(eff_addr);
                        mem_wdata <= op_b;
                        mem_we    <= (cls == CLS_STORE);
                        retire    <= (cls == CLS_STORE);
                        state     <= ST_MEM;
                    end
                end
                ST_MEM: begin
                    retire <= (cls == CLS_LOAD);
                    state  <= (cls == CLS_LOAD) ? ST_WRITEBACK : ST_IDLE;
                end
                ST_WRITEBACK: begin
                    if (wr_ok) begin
                        regs[rd] <= (cls == CLS_LOAD) ? mem_rdata : res_q;
                    end
                    if (cls == CLS_ALU) begin
                        flag_z <= zero_q;
                        flag_c <= carry_q;
                    end
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_cu.sv
// ============================================================================
// Module      : tb_multicycle_cu
// Description : Directed self-checking bench for multicycle_cu.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_multicycle_cu;
    import cu_pkg::*;

    localparam int DW = 8;
    localparam int AB = 5;
    localparam int RB = 2;
    localparam int IW = 2 + 3 * RB + DW + 4;
`ifdef MULTICYCLE_CU_REG0_ZERO_EN
    localparam bit Z0 = 1'b1;
`else
    localparam bit Z0 = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [IW-1:0] instr;
    logic          instr_valid;
    logic          instr_ready;
    logic [AB-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [DW-1:0] mem_rdata = '0;
    logic          retire;
    logic          illegal;
    logic          flag_z;
    logic          flag_c;
    logic [RB-1:0] dbg_sel;
    logic [DW-1:0] dbg_data;

    multicycle_cu #(.DATA_WIDTH(DW), .NUM_REGS(4), .ADDR_BITS(AB)) dut (
        .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_rdata(mem_rdata), .retire(retire), .illegal(illegal),
        .flag_z(flag_z), .flag_c(flag_c), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    always #10 clk = ~clk;

    // Memory model: read data appears one cycle after the address
    logic [DW-1:0] mem_model [32];
    always @(posedge clk) mem_rdata <= mem_model[mem_addr];

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [IW-1:0] enc(input logic [1:0] cls, input logic [1:0] rd,
                                          input logic [1:0] rs1, input logic [1:0] rs2,
                                          input logic [7:0] off, input logic [3:0] op);
        return {cls, rd, rs1, rs2, off, op};
    endfunction

    int            ret_cyc, ret_cnt, ill_cyc, we_cnt, we_cyc, rdy_cyc;
    logic [AB-1:0] we_addr, mem3_addr;
    logic [DW-1:0] we_data;

    task automatic run(input logic [IW-1:0] ins);
        int waited = 0;
        ret_cyc = 0; ret_cnt = 0; ill_cyc = 0; we_cnt = 0; we_cyc = 0; rdy_cyc = 0;
        we_addr = '0; we_data = '0; mem3_addr = '0;
        @(negedge clk);
        while (!instr_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("ready_wait", {31'b0, instr_ready}, 1);
        instr = ins;
        instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            if (retire) begin
                ret_cnt++;
                if (ret_cyc == 0) ret_cyc = c;
            end
            if (illegal && ill_cyc == 0) ill_cyc = c;
            if (mem_we) begin
                we_cnt++; we_cyc = c; we_addr = mem_addr; we_data = mem_wdata;
            end
            if (c == 3) mem3_addr = mem_addr;
            if (instr_ready && rdy_cyc == 0) rdy_cyc = c;
            @(posedge clk); #1;
        end
    endtask

    task automatic check_regs(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                              input logic [7:0] e2, input logic [7:0] e3);
        logic [7:0] e [4];
        e = '{e0, e1, e2, e3};
        for (int i = 0; i < 4; i++) begin
            dbg_sel = 2'(i);
            #1;
            check($sformatf("%s_r%0d", tag, i), {24'b0, dbg_data}, {24'b0, e[i]});
        end
    endtask

    task automatic check_flags(input string tag, input logic z, input logic c);
        check({tag, "_z"}, {31'b0, flag_z}, {31'b0, z});
        check({tag, "_c"}, {31'b0, flag_c}, {31'b0, c});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int seen_we;
        instr = '0; instr_valid = 1'b0; dbg_sel = '0;
        for (int i = 0; i < 32; i++) mem_model[i] = '0;
        mem_model[7] = 8'hFF;
        mem_model[4] = 8'hA5;
        rst = 1'b1;
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready",  {31'b0, instr_ready}, 0);
        check("rst_we",     {31'b0, mem_we}, 0);
        check("rst_retire", {31'b0, retire}, 0);
        check("rst_illegal",{31'b0, illegal}, 0);
        check("rst_addr",   {27'b0, mem_addr}, 0);
        check("rst_wdata",  {24'b0, mem_wdata}, 0);
        check_flags("rst", 1'b0, 1'b0);
        check_regs("rst", 8'h00, 8'h01, 8'h02, 8'h03);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("ready_after_rst", {31'b0, instr_ready}, 1);

        // ADD r1 = r2 + r3 = 5
        run(enc(CLS_ALU, 2'd1, 2'd2, 2'd3, 8'h00, OP_ADD));
        check("add_lat", ret_cyc, 3);
        check("add_rdy", rdy_cyc, 4);
        check("add_we", we_cnt, 0);
        check_regs("add", 8'h00, 8'h05, 8'h02, 8'h03);
        check_flags("add", 1'b0, 1'b0);

        // STORE mem[r3 + 0x1E] = r2 -> address wraps to 0x01
        run(enc(CLS_STORE, 2'd0, 2'd3, 2'd2, 8'h1E, 4'h0));
        check("st_lat", ret_cyc, 3);
        check("st_we_cnt", we_cnt, 1);
        check("st_we_cyc", we_cyc, 3);
        check("st_addr", {27'b0, we_addr}, 32'h01);
        check("st_data", {24'b0, we_data}, 32'h02);
        check("st_ill", ill_cyc, 0);
        check_regs("st", 8'h00, 8'h05, 8'h02, 8'h03);

        // SUB r3 = r2 - r1 = 2 - 5 -> 0xFD with borrow
        run(enc(CLS_ALU, 2'd3, 2'd2, 2'd1, 8'h00, OP_SUB));
        check("sub_lat", ret_cyc, 3);
        check_regs("sub", 8'h00, 8'h05, 8'h02, 8'hFD);
        check_flags("sub", 1'b0, 1'b1);

        // Illegal opcode 0xC
        run(enc(CLS_ALU, 2'd1, 2'd2, 2'd3, 8'h00, 4'hC));
        check("ill_cyc", ill_cyc, 2);
        check("ill_ret", ret_cnt, 0);
        check("ill_rdy", rdy_cyc, 3);
        check_regs("ill", 8'h00, 8'h05, 8'h02, 8'hFD);
        check_flags("ill", 1'b0, 1'b1);

        // NOP
        run(enc(CLS_NOP, 2'd1, 2'd2, 2'd3, 8'h55, 4'h0));
        check("nop_lat", ret_cyc, 1);
        check("nop_rdy", rdy_cyc, 2);
        check_regs("nop", 8'h00, 8'h05, 8'h02, 8'hFD);

        // Reset pulsed while a STORE sits in DECODE
        seen_we = 0;
        @(negedge clk);
        instr = enc(CLS_STORE, 2'd0, 2'd3, 2'd2, 8'h1E, 4'h0);
        instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (mem_we) seen_we++;
            @(posedge clk); #1;
        end
        check("abort_ready_in_rst", {31'b0, instr_ready}, 0);
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (mem_we) seen_we++;
            @(posedge clk); #1;
        end
        check("abort_we", seen_we, 0);
        check_regs("abort", 8'h00, 8'h01, 8'h02, 8'h03);
        check_flags("abort", 1'b0, 1'b0);

        // LOAD r2 = mem[r0 + 7] = 0xFF; opcode field ignored
        run(enc(CLS_LOAD, 2'd2, 2'd0, 2'd0, 8'h07, 4'hF));
        check("ld1_lat", ret_cyc, 4);
        check("ld1_ill", ill_cyc, 0);
        check("ld1_we", we_cnt, 0);
        check("ld1_addr", {27'b0, mem3_addr}, 32'h07);
        check_regs("ld1", 8'h00, 8'h01, 8'hFF, 8'h03);

        // ADD r0 = r2 + r1 = 0x100 -> 0 with carry
        run(enc(CLS_ALU, 2'd0, 2'd2, 2'd1, 8'h00, OP_ADD));
        check_regs("addc", 8'h00, 8'h01, 8'hFF, 8'h03);
        check_flags("addc", 1'b1, 1'b1);

        // LOAD r1 = mem[r0 + 4] = 0xA5
        run(enc(CLS_LOAD, 2'd1, 2'd0, 2'd3, 8'h04, 4'h0));
        check("ld2_lat", ret_cyc, 4);
        check("ld2_addr", {27'b0, mem3_addr}, 32'h04);
        check_regs("ld2", 8'h00, 8'hA5, 8'hFF, 8'h03);

        // SHL1 r3 = 0xFF << 1
        run(enc(CLS_ALU, 2'd3, 2'd2, 2'd0, 8'h00, OP_SHL1));
        check_regs("shl", 8'h00, 8'hA5, 8'hFF, 8'hFE);
        check_flags("shl", 1'b0, 1'b1);

        // SHR1 r3 = 0xA5 >> 1
        run(enc(CLS_ALU, 2'd3, 2'd1, 2'd0, 8'h00, OP_SHR1));
        check_regs("shr", 8'h00, 8'hA5, 8'hFF, 8'h52);
        check_flags("shr", 1'b0, 1'b1);

        // AND r0 = 0xA5 & 0xFF
        run(enc(CLS_ALU, 2'd0, 2'd1, 2'd2, 8'h00, OP_AND));
        check_regs("and", Z0 ? 8'h00 : 8'hA5, 8'hA5, 8'hFF, 8'h52);
        check_flags("and", 1'b0, 1'b0);

        // XOR r2 = r2 ^ r2 with rd aliasing both sources
        run(enc(CLS_ALU, 2'd2, 2'd2, 2'd2, 8'h00, OP_XOR));
        check_regs("xor", Z0 ? 8'h00 : 8'hA5, 8'hA5, 8'h00, 8'h52);
        check_flags("xor", 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
